// File: rtl/sync_fifo_fwft_pkg.sv
// Shared types and helpers for the single-clock FIFO: the registered flag
// bundle and the function that derives every flag from a fill level.
package sync_fifo_fwft_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    function automatic fifo_flags_t derive_flags(input int level, input int depth,
                                                 input int af_buffer, input int ae_buffer);
        fifo_flags_t f;
        f.full         = (level == depth);
        f.almost_full  = ((depth - level) <= af_buffer);
        f.empty        = (level == 0);
        f.almost_empty = (level <= ae_buffer);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_mem.sv
// Register-array storage for the FIFO: one write port plus either an
// asynchronous (FWFT) or a registered read port.
module sync_fifo_fwft_mem
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic unused_inputs;
            assign unused_inputs = reset_i ^ rd_en_i;
            assign rdata_o       = mem_q[raddr_i];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rdata_q;

            // Output word only changes on an accepted read, so it survives flush.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    rdata_q <= '0;
                end else if (rd_en_i) begin
                    rdata_q <= mem_q[raddr_i];
                end
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with optional first-word-fall-through, fill level,
// one-cycle flush and sticky overflow/underflow flags.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int ADDR_WIDTH          = 2,
    parameter int ALMOST_FULL_BUFFER  = 2,
    parameter int ALMOST_EMPTY_BUFFER = 2,
    parameter int FWFT                = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  err_clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wfull_o,
    output logic                  walmost_full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rempty_o,
    output logic                  ralmost_empty_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (ADDR_WIDTH < 1) begin : g_bad_addr_width
            $error("sync_fifo_fwft: ADDR_WIDTH must be at least 1");
        end
        if (ALMOST_FULL_BUFFER >= DEPTH) begin : g_bad_af_buffer
            $error("sync_fifo_fwft: ALMOST_FULL_BUFFER must be below DEPTH");
        end
        if (ALMOST_EMPTY_BUFFER >= DEPTH) begin : g_bad_ae_buffer
            $error("sync_fifo_fwft: ALMOST_EMPTY_BUFFER must be below DEPTH");
        end
    endgenerate

    logic [ADDR_WIDTH:0] wr_ptr_q, rd_ptr_q, wr_ptr_next, rd_ptr_next;
    logic [ADDR_WIDTH:0] level_q, level_next;
    fifo_flags_t         flags_q, flags_next;
    logic                overflow_q, underflow_q, overflow_next, underflow_next;
    logic                wr_accept, rd_accept;

    // Acceptance looks only at this cycle's registered flags; flush swallows
    // both requests so a dropped write never counts as an overflow.
    always_comb begin
        wr_accept   = wr_en_i & ~flags_q.full  & ~flush_i;
        rd_accept   = rd_en_i & ~flags_q.empty & ~flush_i;
        wr_ptr_next = wr_ptr_q + (ADDR_WIDTH + 1)'(wr_accept);
        rd_ptr_next = flush_i ? wr_ptr_q : rd_ptr_q + (ADDR_WIDTH + 1)'(rd_accept);
        level_next  = wr_ptr_next - rd_ptr_next;
        flags_next  = derive_flags(int'(level_next), DEPTH,
                                   ALMOST_FULL_BUFFER, ALMOST_EMPTY_BUFFER);
        overflow_next  = (wr_en_i & flags_q.full  & ~flush_i) | (overflow_q  & ~err_clr_i);
        underflow_next = (rd_en_i & flags_q.empty & ~flush_i) | (underflow_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            flags_q     <= derive_flags(0, DEPTH, ALMOST_FULL_BUFFER, ALMOST_EMPTY_BUFFER);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_next;
            rd_ptr_q    <= rd_ptr_next;
            level_q     <= level_next;
            flags_q     <= flags_next;
            overflow_q  <= overflow_next;
            underflow_q <= underflow_next;
        end
    end

    sync_fifo_fwft_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) u_mem (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_en_i (wr_accept),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wdata_i),
        .rd_en_i (rd_accept),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (rdata_o)
    );

    assign wfull_o         = flags_q.full;
    assign walmost_full_o  = flags_q.almost_full;
    assign rempty_o        = flags_q.empty;
    assign ralmost_empty_o = flags_q.almost_empty;
    assign level_o         = level_q;
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a registered-read and an FWFT instance with identical directed
// vectors and compares both against hand-computed expectations.
module tb_sync_fifo_fwft;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0, err_clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] wdata = '0;

    logic [1:0]  wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
    logic [15:0] rdata [2];
    logic [2:0]  level [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        sync_fifo_fwft #(
            .DATA_WIDTH          (16),
            .ADDR_WIDTH          (2),
            .ALMOST_FULL_BUFFER  (2),
            .ALMOST_EMPTY_BUFFER (2),
            .FWFT                (d)
        ) dut (
            .clk_i           (clk),
            .reset_i         (reset),
            .flush_i         (flush),
            .err_clr_i       (err_clr),
            .wr_en_i         (wr_en),
            .wdata_i         (wdata),
            .wfull_o         (wfull[d]),
            .walmost_full_o  (walmost_full[d]),
            .rd_en_i         (rd_en),
            .rdata_o         (rdata[d]),
            .rempty_o        (rempty[d]),
            .ralmost_empty_o (ralmost_empty[d]),
            .level_o         (level[d]),
            .overflow_o      (overflow[d]),
            .underflow_o     (underflow[d])
        );
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Flags follow directly from the expected level of a depth-4 FIFO.
    task automatic check_state(input string tag, input int exp_level,
                               input logic exp_ov, input logic exp_un);
        for (int d = 0; d < 2; d++) begin
            string p;
            p = $sformatf("%s/fwft%0d", tag, d);
            check_output({p, " level"},        32'(level[d]),         32'(exp_level));
            check_output({p, " empty"},        32'(rempty[d]),        32'(exp_level == 0));
            check_output({p, " almost_empty"}, 32'(ralmost_empty[d]), 32'(exp_level <= 2));
            check_output({p, " full"},         32'(wfull[d]),         32'(exp_level == 4));
            check_output({p, " almost_full"},  32'(walmost_full[d]),  32'(exp_level >= 2));
            check_output({p, " overflow"},     32'(overflow[d]),      32'(exp_ov));
            check_output({p, " underflow"},    32'(underflow[d]),     32'(exp_un));
        end
    endtask

    task automatic check_rdata(input string tag, input logic [15:0] expected);
        check_output({tag, " rdata/fwft0"}, 32'(rdata[0]), 32'(expected));
    endtask

    task automatic check_head(input string tag, input logic [15:0] expected);
        check_output({tag, " head/fwft1"}, 32'(rdata[1]), 32'(expected));
    endtask

    task automatic apply_stimulus(input logic wr, input logic [15:0] d, input logic rd,
                                  input logic fl, input logic clr);
        wr_en   = wr;
        wdata   = d;
        rd_en   = rd;
        flush   = fl;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_word(input logic [15:0] d);
        apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_word();
        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic read_write(input logic [15:0] d);
        apply_stimulus(1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_errors();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        idle();
        check_state("reset", 0, 1'b0, 1'b0);
        check_rdata("reset", 16'h0);
        reset = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            write_word(16'(i));
            check_state($sformatf("fill%0d", i), i, 1'b0, 1'b0);
            if (i == 1) check_head("fill1", 16'h1);
        end

        write_word(16'h5);
        check_state("overflow", 4, 1'b1, 1'b0);

        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("drain%0d", i), 16'(i));
            read_word();
            check_rdata($sformatf("drain%0d", i), 16'(i));
            check_state($sformatf("drain%0d", i), 4 - i, 1'b1, 1'b0);
        end

        read_word();
        check_state("underflow", 0, 1'b1, 1'b1);
        check_rdata("underflow hold", 16'h4);

        clear_errors();
        check_state("err_clr", 0, 1'b0, 1'b0);

        write_word(16'd10);
        write_word(16'd11);
        for (int i = 0; i < 10; i++) begin
            check_head($sformatf("rdwr%0d", i), 16'(10 + i));
            read_write(16'(12 + i));
            check_rdata($sformatf("rdwr%0d", i), 16'(10 + i));
            check_state($sformatf("rdwr%0d", i), 2, 1'b0, 1'b0);
        end

        // Words 20 and 21 remain; top up to full, then rd+wr must drop the write.
        write_word(16'd22);
        write_word(16'd23);
        check_state("refill", 4, 1'b0, 1'b0);
        read_write(16'd24);
        check_state("full rdwr", 3, 1'b1, 1'b0);
        check_rdata("full rdwr", 16'd20);
        clear_errors();
        check_state("full rdwr clr", 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_head($sformatf("tail%0d", i), 16'(21 + i));
            read_word();
            check_rdata($sformatf("tail%0d", i), 16'(21 + i));
        end
        check_state("tail done", 0, 1'b0, 1'b0);

        read_write(16'h30);
        check_state("empty rdwr", 1, 1'b0, 1'b1);
        check_rdata("empty rdwr hold", 16'd23);
        check_head("empty rdwr", 16'h30);
        clear_errors();
        read_word();
        check_rdata("empty rdwr pop", 16'h30);
        check_state("empty rdwr pop", 0, 1'b0, 1'b0);

        read_word();
        write_word(16'h41);
        write_word(16'h42);
        write_word(16'h43);
        check_state("pre flush", 3, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'h44, 1'b0, 1'b1, 1'b0);
        check_state("flush", 0, 1'b0, 1'b1);
        check_rdata("flush hold", 16'h30);
        write_word(16'hABCD);
        check_state("post flush", 1, 1'b0, 1'b1);
        check_head("post flush", 16'hABCD);
        read_word();
        check_rdata("post flush", 16'hABCD);

        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        check_state("clr vs new error", 0, 1'b0, 1'b1);
        clear_errors();
        check_state("clr final", 0, 1'b0, 1'b0);

        write_word(16'h1);
        write_word(16'h2);
        read_write(16'h3);
        read_write(16'h4);
        reset = 1'b1;
        read_write(16'h5);
        check_state("mid reset", 0, 1'b0, 1'b0);
        check_rdata("mid reset", 16'h0);
        reset = 1'b0;
        idle();
        check_state("after reset", 0, 1'b0, 1'b0);
        write_word(16'h55);
        check_state("after reset wr", 1, 1'b0, 1'b0);
        check_head("after reset wr", 16'h55);
        read_word();
        check_rdata("after reset rd", 16'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
